// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter: the dmem word-address
//   width, the starvation counter width, the read-owner encoding and a small
//   helper that classifies an access as a read from its byte enables.
package dmem_arbiter_pkg;

    // dmem word-address width, reused as the default ADDR_W
    localparam int DMEM_ABUS = 14;

    // Width of the DMA starvation counter (limit range 1..255)
    localparam int CNT_W = 8;

    // Who owns the read data returning from the BRAM this cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    // An access with no byte enables set is a read
    function automatic logic is_read(input logic [3:0] we);
        return (we == 4'b0000);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the three buses around the arbiter:
//     core side : core_req_i/we/addr/din in, core_stall_o/rdata/rvalid out
//     DMA side  : dma_valid_i/we/addr/din in, dma_ready_o/rdata/rvalid out
//     BRAM side : dmem_ena/wea/addra/dina out, dmem_douta_i in
//   Modport slave is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DMEM_ABUS
) ();

    logic              core_req_i;
    logic [3:0]        core_we_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [31:0]       core_din_i;
    logic              core_stall_o;
    logic [31:0]       core_rdata_o;
    logic              core_rvalid_o;

    logic              dma_valid_i;
    logic [3:0]        dma_we_i;
    logic [ADDR_W-1:0] dma_addr_i;
    logic [31:0]       dma_din_i;
    logic              dma_ready_o;
    logic [31:0]       dma_rdata_o;
    logic              dma_rvalid_o;

    logic              dmem_ena_o;
    logic [3:0]        dmem_wea_o;
    logic [ADDR_W-1:0] dmem_addra_o;
    logic [31:0]       dmem_dina_o;
    logic [31:0]       dmem_douta_i;

    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_din_i,
        output core_stall_o, core_rdata_o, core_rvalid_o,
        input  dma_valid_i, dma_we_i, dma_addr_i, dma_din_i,
        output dma_ready_o, dma_rdata_o, dma_rvalid_o,
        output dmem_ena_o, dmem_wea_o, dmem_addra_o, dmem_dina_o,
        input  dmem_douta_i
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_din_i,
        input  core_stall_o, core_rdata_o, core_rvalid_o,
        output dma_valid_i, dma_we_i, dma_addr_i, dma_din_i,
        input  dma_ready_o, dma_rdata_o, dma_rvalid_o,
        input  dmem_ena_o, dmem_wea_o, dmem_addra_o, dmem_dina_o,
        output dmem_douta_i
    );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// starve_counter
//   Saturating counter of consecutive cycles the DMA requester has waited.
//   Ports: clk, rst (sync, active-high), inc (count one more wait cycle),
//   clr (clear, dominates inc), limit_reached (count == STARVE_LIMIT).
module starve_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_reached
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Wait-cycle counter: clear wins, otherwise count up and hold at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r < LIMIT_C)) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign limit_reached = (cnt_r == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single BRAM port of the data memory between the core MEM
//   stage (priority) and a DMA requester. A saturating starvation counter
//   lets the DMA win one beat after STARVE_LIMIT consecutive wait cycles.
//   Ports: clk, rst (sync, active-high), bus (dmem_arbiter_if.slave) carrying
//   the core request/stall/read-return, the DMA valid/ready/read-return and
//   the BRAM port-A signals. Read data is a passthrough of dmem_douta_i; the
//   matching rvalid is qualified by a registered read-owner tag.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ABUS,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);

    logic              starved_s;
    logic              grant_dma_s;
    logic              grant_core_s;
    logic              cnt_clr_s;
    logic              cnt_inc_s;
    logic              ena_s;
    logic [3:0]        wea_s;
    logic [ADDR_W-1:0] addr_s;
    logic [31:0]       din_s;
    logic              core_rvalid_s;
    logic              dma_rvalid_s;
    owner_e            rd_owner_r;
    owner_e            rd_owner_nxt_s;

    // Core-first grant, overridden by a starved DMA; nothing granted in reset
    always_comb begin
        grant_dma_s  = 1'b0;
        grant_core_s = 1'b0;
        if (rst) begin
            grant_dma_s  = 1'b0;
            grant_core_s = 1'b0;
        end else begin
            grant_dma_s  = bus.dma_valid_i && (!bus.core_req_i || starved_s);
            grant_core_s = bus.core_req_i && !grant_dma_s;
        end
    end

    // A served or withdrawn DMA request restarts the wait count
    assign cnt_clr_s = grant_dma_s || !bus.dma_valid_i;
    assign cnt_inc_s = !cnt_clr_s;

    starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk           (clk),
        .rst           (rst),
        .inc           (cnt_inc_s),
        .clr           (cnt_clr_s),
        .limit_reached (starved_s)
    );

    // BRAM port mux: the granted requester drives the port, idle port is quiet
    always_comb begin
        ena_s  = 1'b0;
        wea_s  = 4'b0000;
        addr_s = {ADDR_W{1'b0}};
        din_s  = 32'h0000_0000;
        if (grant_dma_s) begin
            ena_s  = 1'b1;
            wea_s  = bus.dma_we_i;
            addr_s = bus.dma_addr_i;
            din_s  = bus.dma_din_i;
        end else if (grant_core_s) begin
            ena_s  = 1'b1;
            wea_s  = bus.core_we_i;
            addr_s = bus.core_addr_i;
            din_s  = bus.core_din_i;
        end else begin
            ena_s  = 1'b0;
            wea_s  = 4'b0000;
        end
    end

    // Next read owner: tag granted reads only, writes and idle cycles clear it
    always_comb begin
        rd_owner_nxt_s = OWN_NONE;
        if (grant_core_s && is_read(bus.core_we_i)) begin
            rd_owner_nxt_s = OWN_CORE;
        end else if (grant_dma_s && is_read(bus.dma_we_i)) begin
            rd_owner_nxt_s = OWN_DMA;
        end else begin
            rd_owner_nxt_s = OWN_NONE;
        end
    end

    // Read-owner register, aligned with the BRAM's one-cycle read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner_r <= OWN_NONE;
        end else begin
            rd_owner_r <= rd_owner_nxt_s;
        end
    end

    // Decode the owner tag into the two mutually exclusive rvalids
    always_comb begin
        core_rvalid_s = 1'b0;
        dma_rvalid_s  = 1'b0;
        case (rd_owner_r)
            OWN_CORE: core_rvalid_s = 1'b1;
            OWN_DMA:  dma_rvalid_s  = 1'b1;
            OWN_NONE: begin
                core_rvalid_s = 1'b0;
                dma_rvalid_s  = 1'b0;
            end
            default: begin
                core_rvalid_s = 1'b0;
                dma_rvalid_s  = 1'b0;
            end
        endcase
    end

    assign bus.dmem_ena_o    = ena_s;
    assign bus.dmem_wea_o    = wea_s;
    assign bus.dmem_addra_o  = addr_s;
    assign bus.dmem_dina_o   = din_s;

    assign bus.core_stall_o  = bus.core_req_i && grant_dma_s;
    assign bus.core_rdata_o  = bus.dmem_douta_i;
    assign bus.core_rvalid_o = core_rvalid_s;

    assign bus.dma_ready_o   = grant_dma_s;
    assign bus.dma_rdata_o   = bus.dmem_douta_i;
    assign bus.dma_rvalid_o  = dma_rvalid_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed scenarios with literal expectations, then a randomized phase.
//   A behavioural model (core-first grant with a wait-cycle budget, a shadow
//   memory and a one-cycle read return) is compared to the DUT every cycle.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW          = 14;
    localparam int LIMIT       = 8;
    localparam int RAND_CYCLES = 3000;
    localparam int DEPTH       = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    dmem_arbiter_if #(.ADDR_W(AW)) bus ();

    dmem_arbiter #(
        .ADDR_W       (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] bram   [0:DEPTH-1];
    logic [31:0] shadow [0:DEPTH-1];

    function automatic logic [31:0] pattern(input int i);
        return (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000;
    endfunction

    // BRAM behaviour: synchronous read, byte-enabled write
    always @(posedge clk) begin
        if (bus.dmem_ena_o) begin
            if (bus.dmem_wea_o == 4'b0000) begin
                bus.dmem_douta_i <= bram[bus.dmem_addra_o];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.dmem_wea_o[b]) bram[bus.dmem_addra_o][8*b +: 8] <= bus.dmem_dina_o[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model and per-cycle compare ----------------
    int          m_wait      = 0;
    logic        m_core_pend = 1'b0;
    logic        m_dma_pend  = 1'b0;
    logic [31:0] m_rdata     = 32'h0;
    int          m_stall_run = 0;

    // Compare DUT outputs to the model at mid-cycle, then advance the model
    always @(negedge clk) begin
        logic gd, gc;
        logic [3:0] we;
        logic [AW-1:0] ad;
        logic [31:0] dn;
        chk("core_rvalid", 32'(bus.core_rvalid_o), 32'(m_core_pend));
        chk("dma_rvalid", 32'(bus.dma_rvalid_o), 32'(m_dma_pend));
        if (m_core_pend) chk("core_rdata", bus.core_rdata_o, m_rdata);
        if (m_dma_pend) chk("dma_rdata", bus.dma_rdata_o, m_rdata);
        if (rst) begin
            chk("rst_ena", 32'(bus.dmem_ena_o), 32'd0);
            chk("rst_wea", 32'(bus.dmem_wea_o), 32'd0);
            chk("rst_ready", 32'(bus.dma_ready_o), 32'd0);
            chk("rst_stall", 32'(bus.core_stall_o), 32'd0);
            m_wait = 0;
            m_core_pend = 1'b0;
            m_dma_pend = 1'b0;
            m_stall_run = 0;
        end else begin
            gd = bus.dma_valid_i && (!bus.core_req_i || (m_wait >= LIMIT));
            gc = bus.core_req_i && !gd;
            chk("ena", 32'(bus.dmem_ena_o), 32'(gd || gc));
            chk("ready", 32'(bus.dma_ready_o), 32'(gd));
            chk("stall", 32'(bus.core_stall_o), 32'(bus.core_req_i && gd));
            if (bus.core_stall_o) begin
                m_stall_run++;
                chk("stall_run_le1", 32'(m_stall_run <= 1), 32'd1);
            end else begin
                m_stall_run = 0;
            end
            we = gd ? bus.dma_we_i   : bus.core_we_i;
            ad = gd ? bus.dma_addr_i : bus.core_addr_i;
            dn = gd ? bus.dma_din_i  : bus.core_din_i;
            if (gd || gc) begin
                chk("wea", 32'(bus.dmem_wea_o), 32'(we));
                chk("addra", 32'(bus.dmem_addra_o), 32'(ad));
                if (we != 4'b0000) chk("dina", bus.dmem_dina_o, dn);
            end else begin
                chk("idle_wea", 32'(bus.dmem_wea_o), 32'd0);
            end
            m_core_pend = gc && (bus.core_we_i == 4'b0000);
            m_dma_pend  = gd && (bus.dma_we_i == 4'b0000);
            if ((gd || gc) && we == 4'b0000) begin
                m_rdata = shadow[ad];
            end else if (gd || gc) begin
                for (int b = 0; b < 4; b++) begin
                    if (we[b]) shadow[ad][8*b +: 8] = dn[8*b +: 8];
                end
            end
            if (gd || !bus.dma_valid_i) m_wait = 0;
            else if (m_wait < LIMIT) m_wait = m_wait + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic core_drive(input logic req, input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] d);
        bus.core_req_i = req; bus.core_we_i = we; bus.core_addr_i = a; bus.core_din_i = d;
    endtask

    task automatic dma_drive(input logic vld, input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] d);
        bus.dma_valid_i = vld; bus.dma_we_i = we; bus.dma_addr_i = a; bus.dma_din_i = d;
    endtask

    function automatic logic [3:0] rand_we();
        if ($urandom_range(0, 3) < 2) return 4'b0000;
        return 4'($urandom_range(1, 15));
    endfunction

    // Main sequence: directed scenarios, random traffic, summary
    initial begin
        logic c_hold, d_hold;
        logic [31:0] exp_bw;
        for (int i = 0; i < DEPTH; i++) begin
            bram[i]   = pattern(i);
            shadow[i] = pattern(i);
        end
        bram[16]   = 32'hDEAD_BEEF;
        shadow[16] = 32'hDEAD_BEEF;

        // Reset with both requesters active
        rst = 1'b1;
        core_drive(1'b1, 4'b0000, 14'h005, 32'h0);
        dma_drive(1'b1, 4'b0000, 14'h006, 32'h0);
        for (int k = 0; k < 3; k++) begin
            probe();
            chk("reset_ena", 32'(bus.dmem_ena_o), 32'd0);
            chk("reset_ready", 32'(bus.dma_ready_o), 32'd0);
            chk("reset_stall", 32'(bus.core_stall_o), 32'd0);
            chk("reset_rvalids", 32'({bus.core_rvalid_o, bus.dma_rvalid_o}), 32'd0);
            step();
        end
        rst = 1'b0;
        core_drive(1'b0, 4'b0000, 14'h000, 32'h0);
        dma_drive(1'b0, 4'b0000, 14'h000, 32'h0);
        probe();
        chk("wait_cnt_after_reset", 32'(dut.u_starve.cnt_r), 32'd0);

        // Core read alone
        step();
        core_drive(1'b1, 4'b0000, 14'h010, 32'h0);
        probe();
        chk("core_rd_addr", 32'(bus.dmem_addra_o), 32'h010);
        step();
        core_drive(1'b0, 4'b0000, 14'h000, 32'h0);
        probe();
        chk("core_rd_rvalid", 32'(bus.core_rvalid_o), 32'd1);
        chk("core_rd_data", bus.core_rdata_o, 32'hDEAD_BEEF);
        chk("core_rd_dma_rvalid", 32'(bus.dma_rvalid_o), 32'd0);

        // Contention: DMA waits LIMIT cycles, then takes one beat
        step();
        core_drive(1'b1, 4'b0000, 14'h011, 32'h0);
        dma_drive(1'b1, 4'hF, 14'h020, 32'h1234_5678);
        for (int k = 0; k < LIMIT; k++) begin
            probe();
            chk("contend_wait_ready", 32'(bus.dma_ready_o), 32'd0);
            step();
        end
        probe();
        chk("starved_ready", 32'(bus.dma_ready_o), 32'd1);
        chk("starved_stall", 32'(bus.core_stall_o), 32'd1);
        chk("starved_wea", 32'(bus.dmem_wea_o), 32'hF);
        chk("starved_addr", 32'(bus.dmem_addra_o), 32'h020);
        step();
        dma_drive(1'b0, 4'b0000, 14'h000, 32'h0);
        probe();
        chk("regrant_stall", 32'(bus.core_stall_o), 32'd0);
        chk("regrant_ena", 32'(bus.dmem_ena_o), 32'd1);
        chk("regrant_no_rvalid", 32'({bus.core_rvalid_o, bus.dma_rvalid_o}), 32'd0);
        step();
        core_drive(1'b1, 4'b0000, 14'h020, 32'h0);
        step();
        core_drive(1'b0, 4'b0000, 14'h000, 32'h0);
        probe();
        chk("dma_write_readback", bus.core_rdata_o, 32'h1234_5678);

        // Alternating owners
        step();
        core_drive(1'b1, 4'b0000, 14'h001, 32'h0);
        step();
        core_drive(1'b0, 4'b0000, 14'h000, 32'h0);
        dma_drive(1'b1, 4'b0000, 14'h002, 32'h0);
        probe();
        chk("alt_core_rvalid", 32'(bus.core_rvalid_o), 32'd1);
        chk("alt_core_data", bus.core_rdata_o, pattern(1));
        chk("alt_dma_rvalid_lo", 32'(bus.dma_rvalid_o), 32'd0);
        step();
        dma_drive(1'b0, 4'b0000, 14'h000, 32'h0);
        probe();
        chk("alt_dma_rvalid", 32'(bus.dma_rvalid_o), 32'd1);
        chk("alt_dma_data", bus.dma_rdata_o, pattern(2));
        chk("alt_core_rvalid_lo", 32'(bus.core_rvalid_o), 32'd0);

        // Byte write from DMA, then read back
        step();
        dma_drive(1'b1, 4'b0010, 14'h030, 32'hAABB_CCDD);
        probe();
        chk("bw_wea", 32'(bus.dmem_wea_o), 32'h2);
        chk("bw_ready", 32'(bus.dma_ready_o), 32'd1);
        step();
        dma_drive(1'b0, 4'b0000, 14'h000, 32'h0);
        probe();
        chk("bw_no_rvalid", 32'({bus.core_rvalid_o, bus.dma_rvalid_o}), 32'd0);
        step();
        dma_drive(1'b1, 4'b0000, 14'h030, 32'h0);
        step();
        dma_drive(1'b0, 4'b0000, 14'h000, 32'h0);
        probe();
        exp_bw = (pattern(48) & 32'hFFFF_00FF) | 32'h0000_CC00;
        chk("bw_readback", bus.dma_rdata_o, exp_bw);

        // Reset arriving the cycle after a core read grant
        step();
        core_drive(1'b1, 4'b0000, 14'h010, 32'h0);
        step();
        rst = 1'b1;
        core_drive(1'b0, 4'b0000, 14'h000, 32'h0);
        probe();
        chk("midrst_rvalid", 32'(bus.core_rvalid_o), 32'd1);
        chk("midrst_data", bus.core_rdata_o, 32'hDEAD_BEEF);
        step();
        probe();
        chk("midrst_rvalid_gone", 32'(bus.core_rvalid_o), 32'd0);
        step();
        rst = 1'b0;
        probe();
        chk("wait_cnt_after_midrst", 32'(dut.u_starve.cnt_r), 32'd0);

        // Random traffic honouring the hold-while-stalled rules
        for (int n = 0; n < RAND_CYCLES; n++) begin
            probe();
            c_hold = bus.core_req_i && bus.core_stall_o;
            d_hold = bus.dma_valid_i && !bus.dma_ready_o;
            step();
            if (!c_hold) begin
                core_drive($urandom_range(0, 9) < 8, rand_we(), 14'($urandom_range(0, 63)), $urandom);
            end
            if (!d_hold) begin
                dma_drive(1'($urandom_range(0, 1)), rand_we(), 14'($urandom_range(0, 63)), $urandom);
            end else if ($urandom_range(0, 63) == 0) begin
                bus.dma_valid_i = 1'b0;
            end
        end
        probe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-memory BRAM port (1-cycle synchronous read) between the core's MEM stage and a secondary DMA requester (UART program loader). It sits between the MEM stage, the DMA engine and the dmem instance. Read data returns to the writeback stage's load path, and the core stall line feeds the pipeline hazard unit. The core has priority; a saturating starvation counter guarantees DMA forward progress.

## Interface
- ADDR_W, 14, dmem word-address width
- STARVE_LIMIT, 8, consecutive DMA wait cycles before DMA overrides the core; legal range 1..255
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- core_req_i  in  1  core dmem access this cycle
- core_we_i  in  4  byte write enables; 4'b0000 means read
- core_addr_i  in  ADDR_W  word address
- core_din_i  in  32  write data, pre-shifted to byte lanes
- core_stall_o  out  1  core request not granted this cycle; core holds all inputs stable
- core_rdata_o  out  32  read data (dmem_douta_i passthrough)
- core_rvalid_o  out  1  core_rdata_o holds the core read granted in the previous cycle
- dma_valid_i  in  1  DMA request; payload stable while valid and not ready
- dma_ready_o  out  1  DMA granted; transfer occurs on valid && ready
- dma_we_i, dma_addr_i, dma_din_i  in  4 / ADDR_W / 32  as for the core
- dma_rdata_o  out  32  read data passthrough
- dma_rvalid_o  out  1  DMA read granted previous cycle
- dmem_ena_o, dmem_wea_o, dmem_addra_o, dmem_dina_o  out  1 / 4 / ADDR_W / 32  BRAM port A
- dmem_douta_i  in  32  BRAM read data, valid one cycle after ena

## Operation
- Grant is combinational each cycle: grant_dma = dma_valid_i && (!core_req_i || starved); grant_core = core_req_i && !grant_dma.
- starved = (wait_cnt == STARVE_LIMIT).
- wait_cnt (8 bit):
  - reset to 0 when grant_dma or !dma_valid_i;
  - otherwise increments, saturating at STARVE_LIMIT.
- Priority modes are NORMAL (wait_cnt < STARVE_LIMIT) and STARVED (equal). STARVED lasts exactly one granted DMA beat, then returns to NORMAL.
- Port mux:
  - the granted requester drives dmem_*;
  - dmem_ena_o = grant_core || grant_dma;
  - with no grant, dmem_ena_o=0, dmem_wea_o=0 and the other outputs are don't-care.
- Read-owner register rd_owner_q ∈ {NONE, CORE, DMA}:
  - loads CORE/DMA on a granted read (we==0);
  - loads NONE on a write or no grant.
- core_rvalid_o = (rd_owner_q==CORE); dma_rvalid_o = (rd_owner_q==DMA). At most one rvalid is high in any cycle.
- core_stall_o = core_req_i && grant_dma.
- dma_ready_o = grant_dma.
- Writes produce no rvalid.
- No byte extraction or sign extension is done here; the load path owns that.

## Timing
- Reset values: wait_cnt=0, rd_owner_q=NONE, so both rvalid=0.
- While rst is high, grants are forced to 0: dmem_ena_o=0, dma_ready_o=0, core_stall_o=0.
- Read latency: grant in cycle N gives rvalid and data in cycle N+1. Back-to-back reads from either requester sustain 1 access/cycle.
- Simultaneous requests in NORMAL: core wins, DMA waits and wait_cnt increments.
- In STARVED: DMA wins and the core sees exactly one stall cycle.
- With STARVE_LIMIT=1, worst-case core throughput is 50%.
- Reset mid-read: if rst is asserted in cycle N+1 after a read grant in N, rd_owner_q is already loaded and rvalid fires in N+1. A grant in the same cycle as rst does not occur, so no rvalid follows reset.
- DMA dropping valid while waiting is illegal per the handshake; the arbiter tolerates it and clears wait_cnt.

## Structure
- Add to defines.vh: OWN_NONE=2'd0, OWN_CORE=2'd1, OWN_DMA=2'd2, and a DMEM_ABUS width define reused for ADDR_W.
- One sub-module, starve_counter: saturating counter with inc/clr inputs and a limit-reached output, parameterised by STARVE_LIMIT.
- Everything else is flat in dmem_arbiter.

## Test plan
- Reset: rst high 3 cycles with both requesters active -> dmem_ena_o=0, dma_ready_o=0, core_stall_o=0, both rvalid=0; wait_cnt=0 after release.
- Core read alone: core_req, we=0, addr=0x010 at cycle N, BRAM holds 0xDEADBEEF -> dmem_addra_o=0x010 at N; core_rvalid_o=1 with 0xDEADBEEF at N+1; dma_rvalid_o=0.
- Contention, STARVE_LIMIT=8: core reads every cycle, DMA writes 0x12345678 to 0x020 -> DMA waits cycles 0–7. At cycle 8, dma_ready_o=1, core_stall_o=1 and dmem_wea_o=4'hF with addr 0x020. Core regranted at cycle 9; no rvalid at cycle 9 since cycle 8 was a write.
- Alternating owners: core read 0x001 at N, DMA read 0x002 at N+1 (core idle) -> core_rvalid_o at N+1, dma_rvalid_o at N+2, never both high.
- Byte write: DMA we=4'b0010, addr 0x030 with core idle -> dmem_wea_o=4'b0010, dma_ready_o=1 same cycle, no rvalid next cycle.
- Reset mid-operation: core read granted at N, rst asserted at N+1 -> core_rvalid_o=1 at N+1, 0 from N+2; wait_cnt=0 after release.
